param_updown_counter: RTL and testbench
=======================================

Name: param_updown_counter

Overview:
- Parametrised up/down counter that is the successor to the fixed 4-bit up/down counter.
- Adds configurable width and modulus, count enable, and synchronous parallel load.
- Adds a per-cycle direction select, selectable wrap or saturate mode, a terminal-count flag, and registered overflow/underflow pulses.
- Used as a general event/position counter in datapath and control blocks.

Parameters:
- WIDTH, 4, counter and data_in width in bits.
- MOD_VALUE, 16, modulus; count range is 0 .. MOD_VALUE-1. Legal range 2 <= MOD_VALUE <= 2^WIDTH. Out-of-range values are an elaboration error.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset; assertion takes effect immediately, de-assertion is synchronised by the user.
- en  input  1  count enable; counter steps by 1 on a clk edge while high.
- load  input  1  synchronous load of data_in; has priority over en.
- data_in  input  WIDTH  load value.
- up_dn  input  1  direction; 1 = up, 0 = down. Sampled every cycle.
- sat_mode  input  1  boundary mode; 1 = saturate at limits, 0 = wrap.
- data_out  output  WIDTH  current count, registered.
- tc  output  1  terminal count, combinational from data_out and up_dn.
- ovf  output  1  registered one-cycle pulse on an up-step attempted at MOD_VALUE-1.
- unf  output  1  registered one-cycle pulse on a down-step attempted at 0.

Behaviour:
- Reset:
  - While rst=0: data_out=0, ovf=0, unf=0, regardless of clk.
  - First edge evaluation happens on the first rising clk with rst=1.
- Priority per edge: load > en > hold.
- Load:
  - data_out <= data_in if data_in <= MOD_VALUE-1, else data_out <= MOD_VALUE-1 (clamp).
  - Load never sets ovf/unf.
- Up step (en=1, load=0, up_dn=1):
  - If data_out < MOD_VALUE-1: data_out+1.
  - At MOD_VALUE-1: wrap gives 0, saturate holds MOD_VALUE-1. ovf=1 for the next cycle in both modes.
- Down step (en=1, load=0, up_dn=0):
  - If data_out > 0: data_out-1.
  - At 0: wrap gives MOD_VALUE-1, saturate holds 0. unf=1 for the next cycle in both modes.
- Hold (en=0, load=0): data_out unchanged, ovf=unf=0.
- ovf/unf:
  - Registered on the same edge that updates data_out. High for exactly one cycle per boundary event.
  - Re-asserted each consecutive cycle while saturated and still stepping into the limit.
  - ovf and unf are never high together.
- tc = (up_dn & data_out==MOD_VALUE-1) | (~up_dn & data_out==0). Independent of en and sat_mode.
- Arithmetic:
  - No intermediate value ever exceeds MOD_VALUE-1.
  - When MOD_VALUE = 2^WIDTH, the wrap must behave identically to natural binary rollover.
- Direction change: up_dn may toggle on any cycle. The step uses the value sampled at that edge, with no pipeline delay.
- Reset mid-count: count and pulses clear immediately; a pending ovf/unf is dropped.
- Simultaneous load and en: load wins, no step, no pulse.

Test Plan (WIDTH=4, MOD_VALUE=10 unless stated):
- Async reset: rst=0 asserted mid-cycle at count 7 -> data_out=0, ovf=unf=0 before next clk edge. Release rst -> count stays 0 with en=0.
- Wrap up: load 8, en=1, up_dn=1, sat_mode=0 -> data_out 8,9,0,1. tc=1 while 9. ovf=1 only in the cycle data_out=0.
- Wrap down / saturate: load 1, up_dn=0 -> 1,0,9 with unf=1 at 9. Repeat with sat_mode=1 -> 1,0,0,0 with unf=1 on each held cycle.
- Load clamp and priority: data_in=4'b1110, load=1, en=1 -> data_out=9, no ovf. Then load=0 with en=0 -> holds 9.
- Direction toggle: count 5, up_dn alternating 1,0,1 each cycle with en=1 -> 6,5,6. No pulses. tc tracks up_dn combinationally.
- Full-range: WIDTH=4, MOD_VALUE=16, up from 15 wrap -> 0 with ovf=1. Down from 0 -> 15 with unf=1.

Source files
------------

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with load, wrap/saturate modes,
// terminal count and registered overflow/underflow pulses.
module param_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int MOD_VALUE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             up_dn,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] data_out,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  if (MOD_VALUE < 2 || MOD_VALUE > (2 ** WIDTH)) begin : g_bad_mod
    $error("param_updown_counter: MOD_VALUE out of range");
  end

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD_VALUE - 1);

  logic             at_max;
  logic             at_min;
  logic [WIDTH-1:0] cnt_nxt;
  logic             ovf_nxt;
  logic             unf_nxt;

  assign at_max = (data_out == MAX);
  assign at_min = (data_out == '0);
  assign tc     = (up_dn & at_max) | (~up_dn & at_min);

  // +1/-1 only applied away from the limits, so no value exceeds MAX
  always_comb begin
    cnt_nxt = data_out;
    ovf_nxt = 1'b0;
    unf_nxt = 1'b0;
    unique case (1'b1)
      load: begin
        cnt_nxt = (data_in > MAX) ? MAX : data_in;
      end
      (!load && en && up_dn): begin
        if (at_max) begin
          ovf_nxt = 1'b1;
          cnt_nxt = sat_mode ? MAX : '0;
        end else begin
          cnt_nxt = data_out + 1'b1;
        end
      end
      (!load && en && !up_dn): begin
        if (at_min) begin
          unf_nxt = 1'b1;
          cnt_nxt = sat_mode ? '0 : MAX;
        end else begin
          cnt_nxt = data_out - 1'b1;
        end
      end
      default: begin
        cnt_nxt = data_out;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out <= '0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else begin
      data_out <= cnt_nxt;
      ovf      <= ovf_nxt;
      unf      <= unf_nxt;
    end
  end

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter: MOD 10 and MOD 16 instances
// checked against an integer model plus directed expectations.
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [3:0] data_in = '0;
  logic       up_dn = 1'b1;
  logic       sat_mode = 1'b0;

  logic [3:0] q10, q16;
  logic       tc10, tc16, ovf10, ovf16, unf10, unf16;

  int checks = 0;
  int fails = 0;
  bit cmp_on = 1'b0;

  int c10 = 0, c16 = 0;
  bit o10 = 0, u10 = 0, o16 = 0, u16 = 0;

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(4), .MOD_VALUE(10)) u_d10 (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .data_in(data_in), .up_dn(up_dn), .sat_mode(sat_mode),
    .data_out(q10), .tc(tc10), .ovf(ovf10), .unf(unf10)
  );

  param_updown_counter #(.WIDTH(4), .MOD_VALUE(16)) u_d16 (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .data_in(data_in), .up_dn(up_dn), .sat_mode(sat_mode),
    .data_out(q16), .tc(tc16), .ovf(ovf16), .unf(unf16)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nxt(input int c, input int m,
                             output bit o, output bit u);
    int d;
    o = 1'b0;
    u = 1'b0;
    if (load) begin
      d = int'(data_in);
      return (d > m - 1) ? m - 1 : d;
    end
    if (!en) return c;
    if (up_dn) begin
      if (c == m - 1) begin
        o = 1'b1;
        return sat_mode ? c : 0;
      end
      return c + 1;
    end
    if (c == 0) begin
      u = 1'b1;
      return sat_mode ? 0 : m - 1;
    end
    return c - 1;
  endfunction

  function automatic int tc_of(input int c, input int m);
    return (up_dn && c == m - 1) || (!up_dn && c == 0) ? 1 : 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      c10 = 0; c16 = 0;
      o10 = 0; u10 = 0; o16 = 0; u16 = 0;
    end else begin
      c10 = nxt(c10, 10, o10, u10);
      c16 = nxt(c16, 16, o16, u16);
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m10_q", int'(q10), c10);
      chk("m10_tc", int'(tc10), tc_of(c10, 10));
      chk("m10_ovf", int'(ovf10), int'(o10));
      chk("m10_unf", int'(unf10), int'(u10));
      chk("m16_q", int'(q16), c16);
      chk("m16_tc", int'(tc16), tc_of(c16, 16));
      chk("m16_ovf", int'(ovf16), int'(o16));
      chk("m16_unf", int'(unf16), int'(u16));
      chk("m10_excl", int'(ovf10 & unf10), 0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic exp10(input string n, input int q, input int t,
                       input int o, input int u);
    chk({n, "_q"}, int'(q10), q);
    chk({n, "_tc"}, int'(tc10), t);
    chk({n, "_ovf"}, int'(ovf10), o);
    chk({n, "_unf"}, int'(unf10), u);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc();
    cyc();
    exp10("rst_hold", 0, 0, 0, 0);
    rst = 1'b1;
    cmp_on = 1'b1;

    load = 1; data_in = 4'd7;
    cyc();
    load = 0;
    exp10("pre_rst", 7, 0, 0, 0);
    #1 rst = 1'b0;
    #1 exp10("async_rst", 0, 0, 0, 0);
    cyc();
    rst = 1'b1;
    cyc();
    exp10("post_rst", 0, 0, 0, 0);

    sat_mode = 0; up_dn = 1; load = 1; data_in = 4'd8;
    cyc();
    load = 0; en = 1;
    exp10("wu0", 8, 0, 0, 0);
    cyc(); exp10("wu1", 9, 1, 0, 0);
    cyc(); exp10("wu2", 0, 0, 1, 0);
    cyc(); exp10("wu3", 1, 0, 0, 0);
    en = 0;

    up_dn = 0; load = 1; data_in = 4'd1;
    cyc();
    load = 0; en = 1;
    exp10("wd0", 1, 0, 0, 0);
    cyc(); exp10("wd1", 0, 1, 0, 0);
    cyc(); exp10("wd2", 9, 0, 0, 1);
    en = 0;
    cyc(); exp10("wd3", 9, 0, 0, 0);

    sat_mode = 1; load = 1; data_in = 4'd1;
    cyc();
    load = 0; en = 1;
    exp10("sd0", 1, 0, 0, 0);
    cyc(); exp10("sd1", 0, 1, 0, 0);
    cyc(); exp10("sd2", 0, 1, 0, 1);
    cyc(); exp10("sd3", 0, 1, 0, 1);
    en = 0;
    cyc(); exp10("sd4", 0, 1, 0, 0);

    sat_mode = 0; up_dn = 1; en = 1; load = 1; data_in = 4'b1110;
    cyc();
    load = 0; en = 0;
    exp10("clamp", 9, 1, 0, 0);
    chk("clamp16_q", int'(q16), 14);
    cyc(); exp10("clamp_hold", 9, 1, 0, 0);

    sat_mode = 1; en = 1;
    cyc(); exp10("su1", 9, 1, 1, 0);
    cyc(); exp10("su2", 9, 1, 1, 0);
    en = 0; sat_mode = 0;
    cyc();

    up_dn = 0;
    #1 chk("tc_dir_dn", int'(tc10), 0);
    up_dn = 1;
    #1 chk("tc_dir_up", int'(tc10), 1);

    load = 1; data_in = 4'd5;
    cyc();
    load = 0; en = 1; up_dn = 1;
    exp10("dt0", 5, 0, 0, 0);
    cyc(); up_dn = 0; exp10("dt1", 6, 0, 0, 0);
    cyc(); up_dn = 1; exp10("dt2", 5, 0, 0, 0);
    cyc(); exp10("dt3", 6, 0, 0, 0);
    en = 0;

    load = 1; data_in = 4'd15;
    cyc();
    load = 0; en = 1; up_dn = 1;
    chk("fr_q15", int'(q16), 15);
    chk("fr_tc15", int'(tc16), 1);
    cyc();
    up_dn = 0;
    chk("fr_wrap_q", int'(q16), 0);
    chk("fr_wrap_ovf", int'(ovf16), 1);
    cyc();
    en = 0;
    chk("fr_unf_q", int'(q16), 15);
    chk("fr_unf", int'(unf16), 1);
    chk("fr_unf_ovf", int'(ovf16), 0);
    cyc();
    chk("fr_idle_unf", int'(unf16), 0);

    cyc();
    cmp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
